// File: rtl/fetch_stage.sv
// IF stage: owns pc_f, issues one-outstanding imem requests, fills IF/ID.
// Absorbs memory latency, hazard stalls and D-stage redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_f;
    logic [31:0] pc_fetch;
    logic [31:0] hold_instr;
    logic        hold_valid;
    logic        resp;
    logic        hs;
    logic        avail;
    logic [31:0] avail_instr;

    assign resp = (state == WAIT) & imem_rvalid;

    assign imem_req = !reset & !redirect & !stall_f &
        (((state == REQ) & !hold_valid) | (resp & !stall_d));

    assign hs          = imem_req & imem_ready;
    assign avail       = resp | hold_valid;
    assign avail_instr = resp ? imem_rdata : hold_instr;
    assign imem_addr   = pc_f;
    assign fetch_busy  = !reset & !redirect & !avail;

    // A response still in flight at redirect time must be swallowed in DROP.
    always_comb begin
        state_nx = state;
        unique case (state)
            REQ: begin
                if (hs) state_nx = WAIT;
            end
            WAIT: begin
                if (hs)               state_nx = WAIT;
                else if (imem_rvalid) state_nx = REQ;
                else if (redirect)    state_nx = DROP;
            end
            DROP: begin
                if (imem_rvalid) state_nx = REQ;
            end
            default: state_nx = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= REQ;
            pc_f       <= RESET_PC;
            pc_fetch   <= RESET_PC;
            hold_instr <= NOP_INSTR;
            hold_valid <= 1'b0;
            instr_d    <= NOP_INSTR;
            pc_plus4_d <= 32'h0;
            valid_d    <= 1'b0;
        end else begin
            state <= state_nx;

            if (redirect) begin
                pc_f <= redirect_pc;
            end else if (hs) begin
                pc_fetch <= pc_f;
                pc_f     <= pc_f + 32'd4;
            end

            if (redirect) begin
                hold_valid <= 1'b0;
            end else if (stall_d) begin
                if (resp) begin
                    hold_instr <= imem_rdata;
                    hold_valid <= 1'b1;
                end
            end else begin
                hold_valid <= 1'b0;
            end

            if (!stall_d) begin
                if (redirect) begin
                    instr_d <= NOP_INSTR;
                    valid_d <= 1'b0;
                end else if (avail) begin
                    instr_d    <= avail_instr;
                    pc_plus4_d <= pc_fetch + 32'd4;
                    valid_d    <= 1'b1;
                end else begin
                    instr_d <= NOP_INSTR;
                    valid_d <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random memory latency, stalls and redirects,
// checked against an instruction-stream reference model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        fetch_busy;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_d    (instr_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // memory: in-order responses with a per-request latency
    logic [31:0] q_addr[$];
    int          q_wait[$];
    int          rdy_pct = 100;
    int          max_lat = 0;
    bit          stray   = 0;

    // knobs applied at the next falling edge
    bit          n_reset = 1;
    bit          n_sf    = 0;
    bit          n_sd    = 0;
    bit          n_rd    = 0;
    logic [31:0] n_rpc   = 32'h0;

    // reference: next fetch address and next address expected in D
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_dec   = RST_PC;
    bit          warm      = 0;
    bit          p_rst     = 0;
    bit          p_sd      = 0;
    bit          p_rd      = 0;
    bit          p_req     = 0;
    bit          p_rdy     = 0;
    logic [31:0] p_addr    = 32'h0;
    logic [31:0] p_instr   = 32'h0;
    logic [31:0] p_pc4     = 32'h0;
    logic        p_valid   = 1'b0;
    bit          have_ev   = 0;
    logic        exp_v     = 1'b0;
    int          idle      = 0;
    int          n_new     = 0;

    task automatic cycle();
        @(negedge clk);
        reset       = n_reset;
        stall_f     = n_sf;
        stall_d     = n_sd;
        redirect    = n_rd;
        redirect_pc = n_rpc;
        imem_ready  = ($urandom_range(99) < rdy_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (stray) begin
            imem_rvalid = 1'b1;
        end else if (q_addr.size() > 0) begin
            if (q_wait[0] == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(q_addr[0]);
            end else begin
                q_wait[0]--;
            end
        end
        #1;
        if (warm) begin
            if (p_rst) begin
                chk("rst_valid", 32'(valid_d), 32'd0);
                chk("rst_instr", instr_d, NOP);
                chk("rst_pc4", pc_plus4_d, 32'h0);
            end else if (p_sd) begin
                chk("hold_valid", 32'(valid_d), 32'(p_valid));
                chk("hold_instr", instr_d, p_instr);
                chk("hold_pc4", pc_plus4_d, p_pc4);
            end else if (p_rd) begin
                chk("flush_valid", 32'(valid_d), 32'd0);
                chk("flush_instr", instr_d, NOP);
            end else begin
                if (have_ev) chk("avail_valid", 32'(valid_d), 32'(exp_v));
                if (valid_d === 1'b1) begin
                    chk("instr", instr_d, mem_word(exp_dec));
                    chk("pc4", pc_plus4_d, exp_dec + 32'd4);
                    exp_dec = exp_dec + 32'd4;
                    idle = 0;
                    n_new++;
                end else begin
                    chk("bubble_instr", instr_d, NOP);
                end
            end
        end
        if (reset || redirect || stall_f)
            chk("req_blocked", 32'(imem_req), 32'd0);
        if (reset || redirect)
            chk("busy_forced", 32'(fetch_busy), 32'd0);
        if (p_req && !p_rdy && imem_req && !p_rst && !p_rd)
            chk("addr_stable", imem_addr, p_addr);
        if (imem_rvalid && !stray && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_wait.pop_front());
        end
        if (imem_req && imem_ready && !reset) begin
            chk("one_outstanding", 32'(q_addr.size()), 32'd0);
            chk("fetch_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            q_addr.push_back(imem_addr);
            q_wait.push_back($urandom_range(max_lat));
        end
        have_ev = !reset && !redirect && !stall_d;
        exp_v   = !fetch_busy;
        if (reset) begin
            exp_fetch = RST_PC;
            exp_dec   = RST_PC;
            q_addr.delete();
            q_wait.delete();
            idle = 0;
        end else if (redirect) begin
            exp_fetch = redirect_pc;
            exp_dec   = redirect_pc;
        end
        p_rst   = reset;
        p_sd    = stall_d;
        p_rd    = redirect;
        p_req   = imem_req;
        p_rdy   = imem_ready;
        p_addr  = imem_addr;
        p_instr = instr_d;
        p_pc4   = pc_plus4_d;
        p_valid = valid_d;
        warm    = 1;
        idle++;
        if (idle > 80) begin
            chk("progress_idle", 32'(idle), 32'd80);
            idle = 0;
        end
    endtask

    initial begin
        int n0;
        reset       = 1'b1;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        repeat (3) cycle();
        n_reset = 0;

        // zero-wait streaming: one instruction per cycle
        repeat (4) cycle();
        n0 = n_new;
        repeat (16) cycle();
        chk("stream_rate", 32'(n_new - n0), 32'd16);

        // memory not ready: address held, stage busy
        rdy_pct = 0;
        cycle();
        cycle();
        repeat (3) begin
            cycle();
            chk("busy_not_ready", 32'(fetch_busy), 32'd1);
        end
        rdy_pct = 100;
        repeat (4) cycle();

        // reset while a request is outstanding, then a stray response
        max_lat = 3;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (q_addr.size() > 0 && q_wait[0] > 0) break;
        end
        n_reset = 1;
        cycle();
        n_reset = 0;
        stray   = 1;
        cycle();
        stray   = 0;
        repeat (10) cycle();

        // random traffic with stalls, redirects, wrap targets, resets
        rdy_pct = 70;
        max_lat = 2;
        for (int i = 0; i < 3000; i++) begin
            n_reset = ($urandom_range(299) == 0);
            n_sf    = ($urandom_range(9) == 0);
            n_sd    = ($urandom_range(6) == 0);
            n_rd    = !n_reset && !n_sd && ($urandom_range(19) == 0);
            if ($urandom_range(3) == 0)
                n_rpc = 32'hFFFF_FFF8;
            else
                n_rpc = {16'h0, 16'($urandom_range(16'hFFFF))} & 32'hFFFF_FFFC;
            cycle();
        end
        n_reset = 0;
        n_sf    = 0;
        n_sd    = 0;
        n_rd    = 0;
        repeat (10) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
